// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// Signal names carry the direction as seen from the responder (slave side).
interface data_memory_ctrl_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output MemRead_i,
        output MemWrite_i,
        output addr_i,
        output wdata_i,
        input  rdata_o,
        input  stall_o,
        input  ack_o,
        input  err_o
    );

    modport slave (
        input  MemRead_i,
        input  MemWrite_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o,
        output stall_o,
        output ack_o,
        output err_o
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Multi-cycle word-addressed data memory for the MEM stage.
// An accepted access holds the pipeline for LATENCY cycles, then completes
// with a one-cycle ack. Misaligned accesses complete after one stall cycle
// with err_o set and touch neither the array nor rdata_o.
module data_memory_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    data_memory_ctrl_if.slave bus
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Control state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q;

    // Captured request (held for the whole access)
    logic               write_q, write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               mis_q, mis_d;

    // Storage: no reset, contents survive rst_i
    logic [31:0]        mem [DEPTH];

    // Decoded request inputs
    logic               req;
    logic               in_write;
    logic [IDX_W-1:0]   in_idx;
    logic               in_mis;

    // Completion-edge controls (the edge that enters DONE)
    logic               fin;
    logic               fin_write;
    logic [IDX_W-1:0]   fin_idx;
    logic [31:0]        fin_wdata;
    logic               mem_we;
    logic               rd_upd;

    // Address bits above the word index are intentionally ignored (wrap).
    logic               unused_addr;

    assign req         = bus.MemRead_i | bus.MemWrite_i;
    assign in_write    = bus.MemWrite_i;
    assign in_idx      = bus.addr_i[IDX_W+1:2];
    assign in_mis      = |bus.addr_i[1:0];
    assign unused_addr = ^bus.addr_i[31:IDX_W+2];

    // Next-state, capture and completion decode for the access sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        mis_d     = mis_q;
        fin       = 1'b0;
        fin_write = write_q;
        fin_idx   = idx_q;
        fin_wdata = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    write_d = in_write;
                    idx_d   = in_idx;
                    wdata_d = bus.wdata_i;
                    mis_d   = in_mis;
                    if (in_mis || (LATENCY == 1)) begin
                        // Completes on this very edge, so act on the live inputs.
                        state_d   = ST_DONE;
                        ack_d     = 1'b1;
                        err_d     = in_mis;
                        fin       = ~in_mis;
                        fin_write = in_write;
                        fin_idx   = in_idx;
                        fin_wdata = bus.wdata_i;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                    err_d   = mis_q;
                    fin     = ~mis_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // The request still on the inputs is the one just served.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_we = fin & fin_write & ~rst_i;
    assign rd_upd = fin & ~fin_write;

    // Sequencer state and registered outputs; reset aborts any access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (rd_upd) begin
                rdata_q <= mem[fin_idx];
            end
        end
    end

    // Request capture; only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk_i) begin
        write_q <= write_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        mis_q   <= mis_d;
    end

    // Array write on the completion edge of an aligned store.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[fin_idx] <= fin_wdata;
        end
    end

    assign bus.stall_o = ((state_q == ST_IDLE) && req) || (state_q == ST_BUSY);
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance with LATENCY=4 and one
// with LATENCY=1, a reference memory model per instance and a response queue.
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_memory_ctrl_if bus4();
    data_memory_ctrl_if bus1();

    data_memory_ctrl #(.DEPTH(256), .LATENCY(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4.slave)
    );

    data_memory_ctrl #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit   [31:0] mem4 [256];
    bit   [31:0] mem1 [256];
    logic [31:0] rd4 = '0;
    logic [31:0] rd1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 4) begin
            bus4.MemRead_i = rd; bus4.MemWrite_i = wr; bus4.addr_i = a; bus4.wdata_i = w;
        end else begin
            bus1.MemRead_i = rd; bus1.MemWrite_i = wr; bus1.addr_i = a; bus1.wdata_i = w;
        end
    endtask

    task automatic sample(input int d, output logic st, output logic ak,
                          output logic er, output logic [31:0] rdat);
        if (d == 4) begin
            st = bus4.stall_o; ak = bus4.ack_o; er = bus4.err_o; rdat = bus4.rdata_o;
        end else begin
            st = bus1.stall_o; ak = bus1.ack_o; er = bus1.err_o; rdat = bus1.rdata_o;
        end
    endtask

    // Called at a falling edge; d is both the instance selector and its LATENCY.
    // Inputs stay applied through the ack cycle. Returns at ack cycle + 1 time unit.
    task automatic access(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] w,
                          output int acc_cyc);
        exp_t        e;
        exp_t        got_e;
        logic [7:0]  idx;
        logic        mis;
        logic        st, ak, er;
        logic [31:0] rdat;
        int          n;
        logic        got;
        idx   = a[9:2];
        mis   = (a[1:0] != 2'b00);
        e.err = mis;
        e.lat = mis ? 1 : d;
        if (d == 4) begin
            if (!mis) begin
                if (wr) mem4[idx] = w;
                else    rd4 = mem4[idx];
            end
            e.rdata = rd4;
        end else begin
            if (!mis) begin
                if (wr) mem1[idx] = w;
                else    rd1 = mem1[idx];
            end
            e.rdata = rd1;
        end
        sbq.push_back(e);
        drive(d, rd, wr, a, w);
        acc_cyc = cyc;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            #1;
            sample(d, st, ak, er, rdat);
            if (ak) begin
                got   = 1'b1;
                got_e = sbq.pop_front();
                chk("ack_latency", 32'(n), 32'(got_e.lat));
                chk("stall_in_ack", 32'(st), 32'(0));
                chk("err", 32'(er), 32'(got_e.err));
                chk("rdata", rdat, got_e.rdata);
            end else begin
                chk("stall_while_pending", 32'(st), 32'(1));
                @(negedge clk);
                n++;
            end
        end
        chk("ack_seen", 32'(got), 32'(1));
    endtask

    // Quiet cycles: no request, no ack, no stall, rdata held.
    task automatic idle(input int cycles);
        logic        st, ak, er;
        logic [31:0] rdat;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            sample(4, st, ak, er, rdat);
            chk("idle_ack4", 32'(ak), 32'(0));
            chk("idle_stall4", 32'(st), 32'(0));
            chk("idle_rdata4", rdat, rd4);
            sample(1, st, ak, er, rdat);
            chk("idle_ack1", 32'(ak), 32'(0));
            chk("idle_rdata1", rdat, rd1);
        end
    endtask

    initial begin
        int          c, c0, c1, c2;
        logic        st, ak, er;
        logic [31:0] rdat;

        // Reset held two cycles with no request
        rst = 1'b1;
        drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        sample(4, st, ak, er, rdat);
        chk("rst_rdata", rdat, 32'h0);
        chk("rst_ack", 32'(ak), 32'(0));
        chk("rst_err", 32'(er), 32'(0));
        chk("rst_stall", 32'(st), 32'(0));
        sample(1, st, ak, er, rdat);
        chk("rst_rdata1", rdat, 32'h0);
        chk("rst_ack1", 32'(ak), 32'(0));
        rst = 1'b0;

        // Store then load, LATENCY=4
        @(negedge clk); access(4, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, c);
        @(negedge clk); access(4, 1'b1, 1'b0, 32'h10, 32'h0, c);
        idle(2);

        // Misaligned load: one stall, err, rdata unchanged
        @(negedge clk); access(4, 1'b1, 1'b0, 32'h13, 32'h0, c);
        idle(1);

        // Wrap-around: 0x400 aliases word 0
        @(negedge clk); access(4, 1'b0, 1'b1, 32'h400, 32'h5, c);
        @(negedge clk); access(4, 1'b1, 1'b0, 32'h0, 32'h0, c);

        // Both strobes high is a plain write
        @(negedge clk); access(4, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, c);
        // Misaligned store must not disturb the word it points into
        @(negedge clk); access(4, 1'b0, 1'b1, 32'h22, 32'h0BADF00D, c);
        @(negedge clk); access(4, 1'b1, 1'b0, 32'h20, 32'h0, c);
        idle(1);

        // Reset during the second BUSY cycle aborts the store
        @(negedge clk);
        drive(4, 1'b0, 1'b1, 32'h30, 32'h1234);
        #1;
        sample(4, st, ak, er, rdat);
        chk("abort_accept_stall", 32'(st), 32'(1));
        @(negedge clk); #1;
        sample(4, st, ak, er, rdat);
        chk("abort_busy1_stall", 32'(st), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        sample(4, st, ak, er, rdat);
        chk("abort_busy2_ack", 32'(ak), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        rd4 = '0;
        rd1 = '0;
        drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        sample(4, st, ak, er, rdat);
        chk("abort_ack", 32'(ak), 32'(0));
        chk("abort_rdata", rdat, 32'h0);
        idle(5);
        @(negedge clk); access(4, 1'b1, 1'b0, 32'h30, 32'h0, c);
        idle(1);

        // LATENCY=1: back-to-back stores then loads, inputs held in ack cycle
        @(negedge clk); access(1, 1'b0, 1'b1, 32'h0, 32'h11111111, c);
        @(negedge clk); access(1, 1'b0, 1'b1, 32'h4, 32'h22222222, c);
        @(negedge clk); access(1, 1'b0, 1'b1, 32'h8, 32'h33333333, c);
        @(negedge clk); access(1, 1'b1, 1'b0, 32'h0, 32'h0, c0);
        @(negedge clk); access(1, 1'b1, 1'b0, 32'h4, 32'h0, c1);
        @(negedge clk); access(1, 1'b1, 1'b0, 32'h8, 32'h0, c2);
        chk("b2b_gap_1", 32'(c1 - c0), 32'(2));
        chk("b2b_gap_2", 32'(c2 - c1), 32'(2));
        idle(2);
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
